// File: rtl/bus_arbitro.sv
// Shared-bus arbiter/router: polls source FIFOs round-robin, pops one packet,
// and pushes it unmodified to the addressed destination FIFO(s) or drops it.
module bus_arbitro #(
    parameter int              width     = 16,
    parameter int              drivers   = 4,
    parameter int              bits      = 8,
    parameter logic [bits-1:0] broadcast = {bits{1'b1}}
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [drivers-1:0]        pndng,
    input  logic [drivers*width-1:0]  D_pop,
    output logic [drivers-1:0]        pop,
    input  logic [drivers-1:0]        full,
    output logic [drivers-1:0]        push,
    output logic [width-1:0]          D_push,
    output logic                      busy,
    output logic [7:0]                drop_cnt
);

    localparam int SEL_W = (drivers > 1) ? $clog2(drivers) : 1;

    typedef enum logic [1:0] {IDLE, POP, PUSH} state_e;

    state_e             state_q;
    logic [SEL_W-1:0]   sel_q;
    logic [SEL_W-1:0]   last_q;
    logic [width-1:0]   pkt_q;
    logic [drivers-1:0] pop_q;
    logic [drivers-1:0] push_q;
    logic [width-1:0]   d_push_q;
    logic               busy_q;
    logic [7:0]         drop_cnt_q;

    logic [SEL_W-1:0]   grant_d;
    logic [drivers-1:0] grant_oh_d;
    logic [SEL_W-1:0]   scan_idx;
    logic               found;
    logic [width-1:0]   pop_pkt_d;
    logic [drivers-1:0] pop_tgt_d;
    logic [drivers-1:0] pkt_tgt_d;

    // Destination set of a packet: one terminal, all but the source, or none (drop).
    function automatic logic [drivers-1:0] targets(input logic [width-1:0] p,
                                                   input logic [SEL_W-1:0] src);
        logic [bits-1:0]    id;
        logic [drivers-1:0] t;
        id = p[width-1 -: bits];
        t  = '0;
        for (int j = 0; j < drivers; j++) begin
            if (id == broadcast) begin
                t[j] = (j != int'(src));
            end else begin
                t[j] = (j == int'(id)) && (j != int'(src));
            end
        end
        return t;
    endfunction

    // NOTE: every variable gets a default at the top of always_comb so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        grant_d    = last_q;
        grant_oh_d = '0;
        scan_idx   = '0;
        found      = 1'b0;
        for (int k = 1; k <= drivers; k++) begin
            scan_idx = SEL_W'((int'(last_q) + k) % drivers);
            if (!found && pndng[scan_idx]) begin
                grant_d = scan_idx;
                found   = 1'b1;
            end
        end
        grant_oh_d[grant_d] = 1'b1;
    end

    assign pop_pkt_d = D_pop[int'(sel_q)*width +: width];
    assign pop_tgt_d = targets(pop_pkt_d, sel_q);
    assign pkt_tgt_d = targets(pkt_q, sel_q);

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            sel_q      <= '0;
            last_q     <= SEL_W'(drivers - 1);
            pkt_q      <= '0;
            pop_q      <= '0;
            push_q     <= '0;
            d_push_q   <= '0;
            busy_q     <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (|pndng) begin
                        sel_q   <= grant_d;
                        last_q  <= grant_d;
                        pop_q   <= grant_oh_d;
                        busy_q  <= 1'b1;
                        state_q <= POP;
                    end
                end
                POP: begin
                    // Decide the first push attempt from the head word so a free
                    // target is written in the very first PUSH cycle.
                    pop_q   <= '0;
                    pkt_q   <= pop_pkt_d;
                    state_q <= PUSH;
                    if ((pop_tgt_d != '0) && ((pop_tgt_d & full) == '0)) begin
                        push_q   <= pop_tgt_d;
                        d_push_q <= pop_pkt_d;
                    end
                end
                PUSH: begin
                    if (push_q != '0) begin
                        push_q  <= '0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (pkt_tgt_d == '0) begin
                        if (drop_cnt_q != 8'hFF) begin
                            drop_cnt_q <= drop_cnt_q + 8'd1;
                        end
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if ((pkt_tgt_d & full) == '0) begin
                        push_q   <= pkt_tgt_d;
                        d_push_q <= pkt_q;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign pop      = pop_q;
    assign push     = push_q;
    assign D_push   = d_push_q;
    assign busy     = busy_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: doc/bus_arbitro.md
# bus_arbitro

Shared-bus arbiter/router that is the device under test between the per-driver input FIFOs and the per-driver output FIFOs of the data-bus environment. It polls the `drivers` source FIFOs round-robin, pops one packet at a time, decodes the destination ID in the packet's upper bits, and pushes the unmodified packet into the destination output FIFO, or into all other FIFOs for broadcast. Packet format is {ID[bits-1:0], payload[width-bits-1:0]}, matching the driver and monitor transactions.

## Interface
- `width`, 16, packet width in bits, including the ID.
- `drivers`, 4, number of source/destination terminals.
- `bits`, 8, width of the ID field; the ID occupies `D[width-1 -: bits]`.
- `broadcast`, {bits{1'b1}}, ID value meaning "deliver to every terminal except the source".
- `clk` input 1: single clock; all state changes on its rising edge.
- `reset` input 1: reset, asynchronous assert, active-low (0 = reset).
- `pndng` input drivers: source FIFO i holds at least one packet.
- `D_pop` input drivers*width: head packet of source FIFO i, in slice [i*width +: width]; valid whenever `pndng[i]`=1.
- `pop` output drivers: one-cycle pop strobe to source FIFO i.
- `full` input drivers: destination FIFO j cannot accept a push.
- `push` output drivers: one-cycle push strobe to destination FIFO j.
- `D_push` output width: shared bus data; valid while any `push` bit is 1.
- `busy` output 1: FSM is not in IDLE.
- `drop_cnt` output 8: saturating count of discarded packets.

## Operation
- Three-state FSM, all outputs registered:
  - IDLE → POP when any `pndng` bit is 1.
  - POP → PUSH, unconditionally.
  - PUSH → IDLE once the push (or drop) is done; otherwise stays in PUSH.
- IDLE grant:
  - Scan `pndng` from `last+1` upward, wrapping modulo `drivers`; the first set bit is the grant.
  - Register the grant in `sel` and set `last` = `sel`.
  - `last` resets to `drivers-1`, so after reset index 0 has first priority.
- POP:
  - `pop[sel]`=1 for exactly this cycle.
  - `D_pop[sel]` is captured into `pkt` on the closing edge.
- PUSH target set T:
  - `ID < drivers` and `ID != sel`: T = {ID}.
  - `ID == broadcast`: T = all j except `sel`.
  - Any other ID, including self-addressed: T is empty. The packet is dropped, `drop_cnt` increments (saturates at 255), and the FSM returns to IDLE.
- PUSH wait: if any `full[j]` with j in T is 1, hold PUSH with `push`=0. No partial broadcast is ever issued.
- PUSH fire: when no target is full, `push[j]`=1 for all j in T for exactly one cycle, `D_push`=`pkt` unmodified, then go to IDLE.
- At most one packet is in flight, and exactly one `pop` is issued per packet.

## Timing
- Reset values: `pop`=0, `push`=0, `D_push`=0, `busy`=0, `drop_cnt`=0, state=IDLE, `pkt`=0, `sel`=0, `last`=drivers-1.
- Reset mid-operation:
  - All outputs return to their reset values immediately (asynchronously).
  - A packet captured but not yet pushed is lost and is not counted as a drop.
- Cycle-level latency, with `pndng` sampled high at edge k:
  - `pop` is high during cycle k+1 to k+2.
  - `push`/`D_push` are high during cycle k+2 to k+3 if no target is full.
  - IDLE is re-entered at k+3.
  - Peak throughput is one packet per 3 cycles.
- `D_push` holds its last value when `push`=0.
- `pndng` dropping between IDLE and POP is a source-FIFO protocol error and is not checked; the pop is still issued.
- Simultaneous requests on all terminals are served in order last+1, last+2, …; no terminal waits more than `drivers` grants.
- `full` is sampled every PUSH cycle; a push fires in the first cycle in which all targets are not full.

## Test plan
- Unicast: reset release, then source 0 offers 16'h02A5 → `pop[0]` one cycle, 2 cycles after grant `push`=4'b0100 with `D_push`=16'h02A5, `drop_cnt`=0.
- Broadcast: source 1 offers 16'hFF3C → a single push cycle with `push`=4'b1101 and `D_push`=16'hFF3C.
- Round-robin: `pndng`=4'b1111 held, one packet each, IDs all 0 except source 0 sending ID 1 → grant order 0,1,2,3; source 0 is delivered, the ID-0 packet from source 0 would be self-addressed (n/a here), and the others are delivered to terminal 0; `last`=3 at the end.
- Drop: source 2 sends ID 8'h07 and then ID 8'h02 → no `push` for either, `drop_cnt`=2, two `pop[2]` strobes.
- Backpressure: `full[3]`=1 for 5 cycles while source 0 sends ID 3 → FSM holds in PUSH with `busy`=1 and `push`=0; `push[3]` fires in the cycle after `full[3]` falls.
- Async reset: assert `reset`=0 during POP, between clock edges → `pop` drops to 0 immediately; after release, `drop_cnt`=0 and the next grant goes to source 0.
